// File: rtl/matvec_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// matvec_sequencer_pkg
//
// Shared definitions for the matrix-vector sequencer:
//   - ST_* localparams : explicit encodings of the sequencer FSM states
//   - state_t          : FSM state type built on those encodings
//   - idx_width()      : width of the row-index bus for an M-row matrix
// -----------------------------------------------------------------------------
package matvec_sequencer_pkg;

  // Fixed encodings so the state register reads the same in every waveform
  // and netlist, independent of tool enum assignment.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ROW  = 3'd1;
  localparam logic [2:0] ST_CALC = 3'd2;
  localparam logic [2:0] ST_OUT  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,  // waiting for start
    ROW  = ST_ROW,   // offering row_ready, waiting for a row
    CALC = ST_CALC,  // one cycle: register the inner product
    OUT  = ST_OUT,   // presenting res_data/res_idx until accepted
    DONE = ST_DONE   // one-cycle done pulse
  } state_t;

  // Row index width; a single-row matrix still gets a 1-bit index so the
  // port never collapses to zero width.
  function automatic int idx_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage : matvec_sequencer_pkg

// File: rtl/inner_product.sv
// -----------------------------------------------------------------------------
// inner_product
//
// Purely combinational unsigned dot product of two packed N-element vectors.
// Each product and the running sum are kept at DW bits, so the result is the
// exact sum truncated modulo 2^DW.
//
// Ports:
//   inp1 [N*DW-1:0] : first vector, element k at [k*DW +: DW]
//   inp2 [N*DW-1:0] : second vector, same packing
//   outp [DW-1:0]   : sum over k of inp1[k]*inp2[k], modulo 2^DW
// -----------------------------------------------------------------------------
module inner_product #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic [N*DW-1:0] inp1,
  input  logic [N*DW-1:0] inp2,
  output logic [DW-1:0]   outp
);

  logic [DW-1:0] acc;
  logic [DW-1:0] prod;

  // NOTE: every variable assigned in always_comb gets a value at the top of
  // the block; a path that skips an assignment would infer a latch.
  always_comb begin
    acc  = '0;
    prod = '0;
    for (int k = 0; k < N; k++) begin
      // DW-bit assignment context truncates the product before accumulation,
      // which yields the same low DW bits as a full-width sum.
      prod = inp1[k*DW +: DW] * inp2[k*DW +: DW];
      acc  = acc + prod;
    end
    outp = acc;
  end

endmodule : inner_product

// File: rtl/matvec_sequencer.sv
// -----------------------------------------------------------------------------
// matvec_sequencer
//
// Multiplies an M x N matrix, streamed in one row at a time, by an N-element
// vector captured at start. For every row the block accepts the row over a
// valid/ready handshake, spends one cycle registering the inner product, and
// then presents the result with its row index over a second handshake.
// After the last row is accepted it pulses done for one cycle.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : begin a job (honoured only while idle)
//   vec_in     : vector, element k at [k*DW +: DW], sampled with start
//   busy       : high whenever not idle
//   row_valid  : row_data valid
//   row_ready  : block can take a row
//   row_data   : one matrix row, same packing as vec_in
//   res_valid  : res_data/res_idx valid
//   res_ready  : consumer takes the result
//   res_data   : inner product of current row and vector, modulo 2^DW
//   res_idx    : row index of res_data
//   done       : one-cycle pulse at the end of a job
// -----------------------------------------------------------------------------
module matvec_sequencer
  import matvec_sequencer_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int M  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [N*DW-1:0]           vec_in,
  output logic                      busy,
  input  logic                      row_valid,
  output logic                      row_ready,
  input  logic [N*DW-1:0]           row_data,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DW-1:0]             res_data,
  output logic [idx_width(M)-1:0]   res_idx,
  output logic                      done
);

  localparam int              IW       = idx_width(M);
  localparam logic [IW-1:0]   LAST_IDX = IW'(M - 1);

  state_t          state;
  logic [N*DW-1:0] vec_reg;
  logic [N*DW-1:0] row_reg;
  logic [DW-1:0]   res_reg;
  logic [IW-1:0]   idx;
  logic [DW-1:0]   ip_out;

  // Datapath operates only on registered operands, so there is no
  // combinational route from vec_in/row_data to res_data.
  inner_product #(
    .N  (N),
    .DW (DW)
  ) u_inner_product (
    .inp1 (vec_reg),
    .inp2 (row_reg),
    .outp (ip_out)
  );

  // Status outputs are registered and updated together with the state
  // transition that makes them true, so they never glitch.
  // NOTE: all state in this block uses non-blocking assignments so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      row_ready <= 1'b0;
      res_valid <= 1'b0;
      done      <= 1'b0;
      idx       <= '0;
      // NOTE: the operand and result registers are reset too, because
      // res_data must read 0 after reset rather than stale job data.
      vec_reg   <= '0;
      row_reg   <= '0;
      res_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec_reg   <= vec_in;
            idx       <= '0;
            state     <= ROW;
            busy      <= 1'b1;
            row_ready <= 1'b1;
          end
        end

        ROW: begin
          if (row_valid && row_ready) begin
            row_reg   <= row_data;
            state     <= CALC;
            row_ready <= 1'b0;
          end
        end

        // Exactly one cycle: row_reg became stable at the previous edge.
        CALC: begin
          res_reg   <= ip_out;
          state     <= OUT;
          res_valid <= 1'b1;
        end

        // res_reg and idx are untouched until the handshake, which keeps
        // res_data/res_idx stable under backpressure.
        OUT: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              idx       <= idx + 1'b1;
              state     <= ROW;
              row_ready <= 1'b1;
            end
          end
        end

        // start is not looked at here; a new job needs start in IDLE.
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          row_ready <= 1'b0;
          res_valid <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  assign res_data = res_reg;
  assign res_idx  = idx;

endmodule : matvec_sequencer

// File: tb/tb_matvec_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matvec_sequencer
//
// Directed bench for matvec_sequencer with N=4, DW=8, M=4. Inputs change on
// the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_matvec_sequencer;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int M  = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [31:0]   vec_in;
  logic          busy;
  logic          row_valid;
  logic          row_ready;
  logic [31:0]   row_data;
  logic          res_valid;
  logic          res_ready;
  logic [7:0]    res_data;
  logic [1:0]    res_idx;
  logic          done;

  int total;
  int bad;

  matvec_sequencer #(
    .N  (N),
    .DW (DW),
    .M  (M)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .vec_in    (vec_in),
    .busy      (busy),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_idx   (res_idx),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] pk(input logic [7:0] e0, input logic [7:0] e1,
                                     input logic [7:0] e2, input logic [7:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  // Sample start with the given vector at the next rising edge.
  task automatic begin_job(input logic [31:0] vec);
    @(negedge clk);
    vec_in = vec;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Feed one row, wait for its result, optionally stall the result, then
  // accept it.
  task automatic do_row(input logic [31:0] row, input logic [7:0] exp_data,
                        input logic [1:0] exp_idx, input int stall);
    @(negedge clk);
    row_data  = row;
    row_valid = 1'b1;
    res_ready = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (row_ready) break;
      @(negedge clk);
    end
    check("row_ready_wait", row_ready, 1);
    @(posedge clk);
    #1 row_valid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    check("res_valid_wait", res_valid, 1);
    check("res_data", res_data, exp_data);
    check("res_idx", res_idx, exp_idx);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", res_valid, 1);
      check("stall_data", res_data, exp_data);
      check("stall_idx", res_idx, exp_idx);
      check("stall_no_row", row_ready, 0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  // Expect a single-cycle done pulse followed by a return to idle.
  task automatic wait_done();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_pulse", done, 1);
    @(negedge clk);
    check("done_cleared", done, 0);
    check("idle_busy", busy, 0);
  endtask

  int cycles;
  int nres;

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    vec_in    = '0;
    row_valid = 1'b0;
    row_data  = '0;
    res_ready = 1'b0;

    // Reset state.
    #12;
    check("rst_busy", busy, 0);
    check("rst_row_ready", row_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_done", done, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_idx", res_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("wait_idle", busy, 0);

    // Basic job with a 5-cycle result stall on row 1.
    begin_job(pk(1, 2, 3, 4));
    do_row(pk(1, 1, 1, 1), 8'd10, 2'd0, 0);
    do_row(pk(2, 0, 0, 0), 8'd2,  2'd1, 5);
    do_row(pk(0, 0, 0, 1), 8'd4,  2'd2, 0);
    do_row(pk(4, 3, 2, 1), 8'd20, 2'd3, 0);
    wait_done();

    // Overflow: all-255 operands wrap to 4; other rows exercise truncation.
    begin_job(pk(255, 255, 255, 255));
    do_row(pk(255, 255, 255, 255), 8'd4,   2'd0, 0);
    do_row(pk(1, 0, 0, 0),         8'd255, 2'd1, 0);
    do_row(pk(0, 0, 0, 0),         8'd0,   2'd2, 0);
    do_row(pk(2, 2, 2, 2),         8'd248, 2'd3, 0);
    wait_done();

    // Timing: free-flowing handshakes, done in cycle 3*M+1 after start edge.
    // A start pulse mid-job with another vector must be ignored.
    @(negedge clk);
    vec_in    = pk(1, 2, 3, 4);
    row_data  = pk(1, 1, 1, 1);
    row_valid = 1'b1;
    res_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cycles = 0;
    nres   = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      cycles++;
      if (res_valid) begin
        check("t_res_data", res_data, 10);
        check("t_res_idx", res_idx, nres);
        nres++;
      end
      if (cycles == 5) begin
        start  = 1'b1;
        vec_in = pk(9, 9, 9, 9);
      end
      if (cycles == 6) start = 1'b0;
      if (done) break;
    end
    check("t_done_cycle", cycles, 13);
    check("t_results", nres, 4);
    // start held during DONE must not launch a new job.
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("t_done_start_ign", busy, 0);
    @(negedge clk);
    check("t_still_idle", {row_ready, busy}, 0);
    row_valid = 1'b0;
    res_ready = 1'b0;

    // Reset during CALC of row 2 (busy, no handshake pending, index 2).
    @(negedge clk);
    vec_in    = pk(1, 2, 3, 4);
    row_data  = pk(1, 1, 1, 1);
    row_valid = 1'b1;
    res_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (busy && !row_ready && !res_valid && res_idx == 2'd2) break;
    end
    check("r_in_calc2", {busy, row_ready, res_valid, res_idx}, 5'b10010);
    rst_n = 1'b0;
    #1;
    check("r_busy", busy, 0);
    check("r_res_valid", res_valid, 0);
    check("r_res_idx", res_idx, 0);
    check("r_res_data", res_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("r_no_done_idle", {done, busy}, 0);
    end
    row_valid = 1'b0;
    res_ready = 1'b0;

    // Fresh job after reset restarts from row index 0.
    begin_job(pk(2, 2, 2, 2));
    do_row(pk(1, 2, 3, 4), 8'd20, 2'd0, 0);
    do_row(pk(0, 0, 0, 5), 8'd10, 2'd1, 0);
    do_row(pk(3, 3, 3, 3), 8'd24, 2'd2, 0);
    do_row(pk(1, 0, 0, 0), 8'd2,  2'd3, 0);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_matvec_sequencer
